// File: rtl/router_out_arb.sv
// router_out_arb: merges three router FIFOs into one byte stream, one packet at a time.
// In: clock, resetn, vld_out_*, data_out_*, arb_ready. Out: read_enb_*, arb_*, pkt_abort, pkt_count.
module router_out_arb #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] arb_data,
  output logic       arb_valid,
  input  logic       arb_ready,
  output logic       arb_first,
  output logic       arb_last,
  output logic [1:0] arb_port,
  output logic       pkt_abort,
  output logic [7:0] pkt_count
);
  typedef enum logic [1:0] {IDLE, HDR, LEN, BODY} state_e;

  state_e     state_q;
  logic [1:0] port_q, rd_port_q, lst_port_q, ptr_q;
  logic [6:0] cnt_q;
  logic       rd_pend_q, rd_first_q, rd_last_q;
  logic       sk_vld_q, sk_first_q, sk_last_q;
  logic [7:0] sk_data_q;
  logic       out_vld_q, out_first_q, out_last_q;
  logic [7:0] out_data_q;
  logic       abort_q;
  logic [7:0] pkt_q;

  logic [2:0] vld;
  logic [7:0] rdata;
  logic [1:0] pick, c0, c1, c2;
  logic       gnt_vld, free, rd_due, rd, abort, xfer, last_rd;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign vld = {vld_out_2, vld_out_1, vld_out_0};

  // returned byte belongs to the port read last cycle
  always_comb begin
    case (rd_port_q)
      2'd1:    rdata = data_out_1;
      2'd2:    rdata = data_out_2;
      default: rdata = data_out_0;
    endcase
  end

  always_comb begin
    case (port_q)
      2'd0:    gnt_vld = vld_out_0;
      2'd1:    gnt_vld = vld_out_1;
      2'd2:    gnt_vld = vld_out_2;
      default: gnt_vld = 1'b0;
    endcase
  end

  always_comb begin
    c0   = nxt(ptr_q);
    c1   = nxt(c0);
    c2   = nxt(c1);
    pick = 2'd0;
    if (FIXED_PRIO) begin
      priority case (1'b1)
        vld[0]:  pick = 2'd0;
        vld[1]:  pick = 2'd1;
        default: pick = 2'd2;
      endcase
    end else if (vld[c0]) begin
      pick = c0;
    end else if (vld[c1]) begin
      pick = c1;
    end else begin
      pick = c2;
    end
  end

  // a read is only issued when its byte is sure to have a home:
  // the skid slot catches a byte that lands during a stall
  assign free    = !out_vld_q || arb_ready;
  assign rd_due  = (state_q == HDR || state_q == BODY) && free && !sk_vld_q;
  assign rd      = rd_due && gnt_vld;
  assign abort   = rd_due && !gnt_vld;
  assign xfer    = out_vld_q && arb_ready;
  assign last_rd = rd && (state_q == BODY) && (cnt_q == 7'd1);

  assign read_enb_0 = rd && (port_q == 2'd0);
  assign read_enb_1 = rd && (port_q == 2'd1);
  assign read_enb_2 = rd && (port_q == 2'd2);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      port_q     <= 2'd3;
      rd_port_q  <= 2'd0;
      lst_port_q <= 2'd0;
      ptr_q      <= 2'd2;
      cnt_q      <= 7'd0;
      rd_pend_q  <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
      sk_vld_q   <= 1'b0;
      sk_first_q <= 1'b0;
      sk_last_q  <= 1'b0;
      sk_data_q  <= 8'h00;
      out_vld_q  <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= 8'h00;
      abort_q    <= 1'b0;
      pkt_q      <= 8'h00;
    end else begin
      abort_q    <= abort;
      rd_pend_q  <= rd;
      rd_first_q <= rd && (state_q == HDR);
      rd_last_q  <= last_rd;
      if (rd) rd_port_q <= port_q;
      if (last_rd) lst_port_q <= port_q;
      if (xfer && out_last_q) begin
        pkt_q <= pkt_q + 8'd1;
        ptr_q <= lst_port_q;
      end

      if (free) begin
        if (sk_vld_q) begin
          out_vld_q   <= 1'b1;
          out_data_q  <= sk_data_q;
          out_first_q <= sk_first_q;
          out_last_q  <= sk_last_q;
          sk_vld_q    <= 1'b0;
        end else if (rd_pend_q) begin
          out_vld_q   <= 1'b1;
          out_data_q  <= rdata;
          out_first_q <= rd_first_q;
          out_last_q  <= rd_last_q;
        end else begin
          out_vld_q   <= 1'b0;
          out_first_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      end else if (rd_pend_q) begin
        sk_vld_q   <= 1'b1;
        sk_data_q  <= rdata;
        sk_first_q <= rd_first_q;
        sk_last_q  <= rd_last_q;
      end

      unique case (state_q)
        IDLE: begin
          if (|vld) begin
            port_q  <= pick;
            state_q <= HDR;
          end
        end
        HDR: if (rd) state_q <= LEN;
        LEN: begin
          cnt_q   <= {1'b0, rdata[7:2]} + 7'd1;
          state_q <= BODY;
        end
        BODY: begin
          if (rd) begin
            cnt_q <= cnt_q - 7'd1;
            if (cnt_q == 7'd1) begin
              state_q <= IDLE;
              port_q  <= 2'd3;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (abort) begin
        state_q <= IDLE;
        port_q  <= 2'd3;
      end
    end
  end

  assign arb_data  = out_data_q;
  assign arb_valid = out_vld_q;
  assign arb_first = out_first_q;
  assign arb_last  = out_last_q;
  assign arb_port  = port_q;
  assign pkt_abort = abort_q;
  assign pkt_count = pkt_q;
endmodule

// File: tb/tb_router_out_arb.sv
// tb_router_out_arb: directed checks of router_out_arb in round-robin
// and fixed-priority builds, with simple FIFO models on the read side.
module tb_router_out_arb;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn, arb_ready, sel;
  logic [2:0] vld = 3'b000;
  logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00;

  logic [2:0] rd_rr, rd_fp;
  logic [7:0] dat_rr, dat_fp, cnt_rr, cnt_fp;
  logic       v_rr, v_fp, f_rr, f_fp, l_rr, l_fp, a_rr, a_fp;
  logic [1:0] p_rr, p_fp;

  logic [2:0] m_rd;
  logic [7:0] m_d, m_cnt;
  logic       m_v, m_f, m_l, m_a;
  logic [1:0] m_p;
  assign m_rd  = sel ? rd_fp : rd_rr;
  assign m_d   = sel ? dat_fp : dat_rr;
  assign m_cnt = sel ? cnt_fp : cnt_rr;
  assign m_v   = sel ? v_fp : v_rr;
  assign m_f   = sel ? f_fp : f_rr;
  assign m_l   = sel ? l_fp : l_rr;
  assign m_a   = sel ? a_fp : a_rr;
  assign m_p   = sel ? p_fp : p_rr;

  router_out_arb #(.FIXED_PRIO(1'b0)) dut_rr (
    .clock(clock), .resetn(resetn),
    .vld_out_0(vld[0]), .vld_out_1(vld[1]), .vld_out_2(vld[2]),
    .data_out_0(d0), .data_out_1(d1), .data_out_2(d2),
    .read_enb_0(rd_rr[0]), .read_enb_1(rd_rr[1]), .read_enb_2(rd_rr[2]),
    .arb_data(dat_rr), .arb_valid(v_rr), .arb_ready(arb_ready),
    .arb_first(f_rr), .arb_last(l_rr), .arb_port(p_rr),
    .pkt_abort(a_rr), .pkt_count(cnt_rr)
  );

  router_out_arb #(.FIXED_PRIO(1'b1)) dut_fp (
    .clock(clock), .resetn(resetn),
    .vld_out_0(vld[0]), .vld_out_1(vld[1]), .vld_out_2(vld[2]),
    .data_out_0(d0), .data_out_1(d1), .data_out_2(d2),
    .read_enb_0(rd_fp[0]), .read_enb_1(rd_fp[1]), .read_enb_2(rd_fp[2]),
    .arb_data(dat_fp), .arb_valid(v_fp), .arb_ready(arb_ready),
    .arb_first(f_fp), .arb_last(l_fp), .arb_port(p_fp),
    .pkt_abort(a_fp), .pkt_count(cnt_fp)
  );

  logic [7:0] fq0[$], fq1[$], fq2[$];
  logic [9:0] rx[$];
  int         gseq[$];
  logic [1:0] lastp = 2'd3;
  int rdc0 = 0, rdc1 = 0, rdc2 = 0, abort_n = 0, multi_n = 0;
  int n_cmp = 0, n_err = 0;

  always @(posedge clock) begin
    if (m_rd[0] && fq0.size() > 0) d0 <= fq0.pop_front();
    if (m_rd[1] && fq1.size() > 0) d1 <= fq1.pop_front();
    if (m_rd[2] && fq2.size() > 0) d2 <= fq2.pop_front();
    rdc0 += int'(m_rd[0]);
    rdc1 += int'(m_rd[1]);
    rdc2 += int'(m_rd[2]);
    if ($countones(m_rd) > 1) multi_n++;
    if (m_a) abort_n++;
    if (m_v && arb_ready) rx.push_back({m_f, m_l, m_d});
  end

  always @(negedge clock) begin
    vld = {fq2.size() != 0, fq1.size() != 0, fq0.size() != 0};
    if (m_p != lastp) begin
      if (m_p != 2'd3) gseq.push_back(int'(m_p));
      lastp = m_p;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rx(input string tag, input int idx, input logic [9:0] e);
    logic [9:0] o;
    o = (idx < rx.size()) ? rx[idx] : 'x;
    chk(tag, {22'd0, o}, {22'd0, e});
  endtask

  task automatic chk_g(input string tag, input int idx, input int e);
    int o;
    o = (idx < gseq.size()) ? gseq[idx] : -1;
    chk(tag, o, e);
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx.size() < n; i++) step(1);
    chk("wait_rx", 32'(rx.size() >= n), 1);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_valid"}, m_v, 0);
    chk({tag, "_data"}, m_d, 0);
    chk({tag, "_flags"}, {m_f, m_l, m_a}, 0);
    chk({tag, "_port"}, m_p, 3);
    chk({tag, "_count"}, m_cnt, 0);
    chk({tag, "_rd"}, m_rd, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    fq0.delete(); fq1.delete(); fq2.delete();
    step(1);
    resetn = 1'b1;
    step(1);
  endtask

  int b, g, r0, r1, r2, a0;
  logic [9:0] e;

  initial begin
    sel = 1'b0;
    resetn = 1'b0;
    arb_ready = 1'b1;
    step(2);
    chk_rst("reset");
    resetn = 1'b1;
    step(1);

    // port 1, length 3
    b = rx.size(); r1 = rdc1;
    fq1.push_back(8'h0D); fq1.push_back(8'hA1); fq1.push_back(8'hA2);
    fq1.push_back(8'hA3); fq1.push_back(8'h5C);
    wait_rx(b + 5, 60);
    step(3);
    chk("p1_reads", rdc1 - r1, 5);
    chk("p1_other_reads", rdc0 + rdc2, 0);
    chk_rx("p1_hdr", b, 10'h20D);
    chk_rx("p1_b1", b + 1, 10'h0A1);
    chk_rx("p1_b2", b + 2, 10'h0A2);
    chk_rx("p1_b3", b + 3, 10'h0A3);
    chk_rx("p1_par", b + 4, 10'h15C);
    chk("p1_rxlen", rx.size(), b + 5);
    chk("p1_count", m_cnt, 1);
    chk("p1_port_idle", m_p, 3);

    // round-robin, three ports
    do_reset();
    b = rx.size(); g = gseq.size();
    fq0.push_back(8'h04); fq0.push_back(8'h10); fq0.push_back(8'hF0);
    fq1.push_back(8'h05); fq1.push_back(8'h11); fq1.push_back(8'hF1);
    fq2.push_back(8'h06); fq2.push_back(8'h12); fq2.push_back(8'hF2);
    wait_rx(b + 9, 100);
    step(3);
    chk_g("rr_g0", g, 0);
    chk_g("rr_g1", g + 1, 1);
    chk_g("rr_g2", g + 2, 2);
    chk("rr_gcount", gseq.size(), g + 3);
    chk_rx("rr_hdr0", b, 10'h204);
    chk_rx("rr_hdr1", b + 3, 10'h205);
    chk_rx("rr_hdr2", b + 6, 10'h206);
    chk_rx("rr_par2", b + 8, 10'h1F2);
    chk("rr_count", m_cnt, 3);
    chk("rr_port_idle", m_p, 3);

    // fixed priority, port 0 kept full
    sel = 1'b1;
    do_reset();
    b = rx.size(); g = gseq.size();
    fq0.push_back(8'h04); fq0.push_back(8'h20); fq0.push_back(8'hE0);
    fq0.push_back(8'h04); fq0.push_back(8'h21); fq0.push_back(8'hE1);
    fq0.push_back(8'h04); fq0.push_back(8'h22); fq0.push_back(8'hE2);
    fq1.push_back(8'h05); fq1.push_back(8'h31); fq1.push_back(8'hD1);
    fq2.push_back(8'h06); fq2.push_back(8'h32); fq2.push_back(8'hD2);
    wait_rx(b + 15, 200);
    step(3);
    chk_g("fp_g0", g, 0);
    chk_g("fp_g1", g + 1, 0);
    chk_g("fp_g2", g + 2, 0);
    chk_g("fp_g3", g + 3, 1);
    chk_g("fp_g4", g + 4, 2);
    chk_rx("fp_pay1", b + 4, 10'h021);
    chk_rx("fp_pay2", b + 7, 10'h022);
    chk_rx("fp_hdr1", b + 9, 10'h205);
    chk("fp_count", m_cnt, 5);

    // stall mid-body
    sel = 1'b0;
    do_reset();
    b = rx.size(); r0 = rdc0;
    fq0.push_back(8'h18);
    for (int k = 1; k <= 6; k++) fq0.push_back(8'(k));
    fq0.push_back(8'h77);
    wait_rx(b + 3, 40);
    arb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("stall_reads", rdc0 - r0, 5);
      chk("stall_data", m_d, 8'h03);
      chk("stall_valid", m_v, 1);
    end
    arb_ready = 1'b1;
    wait_rx(b + 8, 40);
    step(3);
    for (int k = 0; k < 8; k++) begin
      e = (k == 0) ? 10'h218 : (k == 7) ? 10'h177 : {2'b00, 8'(k)};
      chk_rx("stall_byte", b + k, e);
    end
    chk("stall_rxlen", rx.size(), b + 8);
    chk("stall_reads_total", rdc0 - r0, 8);
    chk("stall_count", m_cnt, 1);

    // port 2 runs dry after 2 of 5 payload bytes
    b = rx.size(); r2 = rdc2; a0 = abort_n;
    fq2.push_back(8'h16); fq2.push_back(8'hB1); fq2.push_back(8'hB2);
    wait_rx(b + 3, 40);
    step(4);
    chk("ab_reads", rdc2 - r2, 3);
    chk("ab_pulses", abort_n - a0, 1);
    chk("ab_count", m_cnt, 1);
    chk("ab_port", m_p, 3);
    chk_rx("ab_hdr", b, 10'h216);
    chk_rx("ab_b1", b + 1, 10'h0B1);
    chk_rx("ab_b2", b + 2, 10'h0B2);
    chk("ab_rxlen", rx.size(), b + 3);

    // zero-length packet
    b = rx.size(); r1 = rdc1;
    fq1.push_back(8'h01); fq1.push_back(8'h9A);
    wait_rx(b + 2, 30);
    step(3);
    chk("z_reads", rdc1 - r1, 2);
    chk_rx("z_hdr", b, 10'h201);
    chk_rx("z_par", b + 1, 10'h19A);
    chk("z_count", m_cnt, 2);

    // asynchronous reset mid-body
    b = rx.size();
    fq0.push_back(8'h20);
    for (int k = 0; k < 8; k++) fq0.push_back(8'h50 + 8'(k));
    fq0.push_back(8'h3C);
    wait_rx(b + 3, 40);
    resetn = 1'b0;
    #1;
    chk_rst("async");
    step(2);
    fq0.delete(); fq1.delete(); fq2.delete();
    step(1);
    resetn = 1'b1;
    step(1);
    b = rx.size(); g = gseq.size();
    fq2.push_back(8'h06); fq2.push_back(8'h42); fq2.push_back(8'hC2);
    fq0.push_back(8'h04); fq0.push_back(8'h40); fq0.push_back(8'hC0);
    wait_rx(b + 6, 60);
    step(3);
    chk_g("post_rst_g0", g, 0);
    chk_g("post_rst_g1", g + 1, 2);
    chk_rx("post_rst_hdr", b, 10'h204);
    chk("post_rst_count", m_cnt, 2);

    chk("onehot_read", multi_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/router_out_arb.md
ROUTER_OUT_ARB -- requirements
Module: router_out_arb

Interface
REQ-001 Parameter: FIXED_PRIO, default 0; 0 = round-robin grant, 1 = fixed priority port 0 > 1 > 2.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 vld_out_0, vld_out_1, vld_out_2  input  1 each  FIFO i non-empty.
REQ-005 data_out_0, data_out_1, data_out_2  input  8 each  FIFO i read data; valid the cycle after read_enb_i.
REQ-006 read_enb_0, read_enb_1, read_enb_2  output  1 each  pop request to FIFO i.
REQ-007 arb_data  output  8  merged output byte.
REQ-008 arb_valid  output  1  arb_data holds a valid byte.
REQ-009 arb_ready  input  1  downstream accepts; a transfer occurs when arb_valid & arb_ready.
REQ-010 arb_first, arb_last  output  1 each  byte is the header / parity byte of a packet.
REQ-011 arb_port  output  2  index of the granted FIFO; 2'b11 when no grant.
REQ-012 pkt_abort  output  1  one-cycle pulse when a packet is aborted.
REQ-013 pkt_count  output  8  count of completed packets; wraps 255 -> 0.

Function
REQ-014 Packet format: header byte = {length[7:2], addr[1:0]}, then length payload bytes, then 1 parity byte; length 0 is legal (header + parity only).
REQ-015 States: IDLE, HDR, LEN, BODY. Reset state is IDLE.
REQ-016 IDLE: if any vld_out_i = 1, select one FIFO, latch the grant, and go to HDR next cycle; otherwise stay in IDLE.
REQ-017 Round-robin (FIXED_PRIO = 0): search starts at the port after the last granted port, wrapping 2 -> 0. The pointer after reset points so that port 0 is searched first.
REQ-018 Fixed priority (FIXED_PRIO = 1): choose the lowest-index requesting port.
REQ-019 Only the granted read_enb_i may be asserted. The read_enb outputs are never high simultaneously.
REQ-020 A read is issued only when the output register is free: arb_valid = 0, or arb_valid & arb_ready in the same cycle.
REQ-021 HDR: issue exactly one read, then go to LEN.
REQ-022 LEN: issue no read. Capture the returned header into the output register with arb_first = 1. Load the remaining-read counter with length + 1 (7-bit, no overflow). Go to BODY.
REQ-023 BODY: issue one read per free cycle and decrement the counter per read. When the read counter reaches 0, go to IDLE.
REQ-024 Returned data loads arb_data and sets arb_valid one cycle after each read_enb pulse. arb_valid is held with arb_data stable until arb_ready.
REQ-025 The parity byte carries arb_last = 1. pkt_count increments on the arb_last transfer.
REQ-026 On the arb_last transfer, the round-robin pointer updates to the granted port.
REQ-027 Abort: if vld_out of the granted port is 0 in HDR or BODY when a read is due, issue no read. Pulse pkt_abort and go to IDLE.
REQ-028 On abort, any byte already in the output register is still delivered, without arb_last. pkt_count is unchanged.
REQ-029 Ports not granted are ignored until the current packet completes or aborts. No preemption occurs.
REQ-030 arb_port equals the latched grant from HDR until return to IDLE; otherwise it is 2'b11.
REQ-031 Throughput: with arb_ready held at 1, one byte is transferred per cycle in BODY. Packet overhead is 2 idle cycles (IDLE and LEN).

Reset
REQ-032 While resetn = 0, all of the following hold:
- state = IDLE
- read_enb_0..2 = 0
- arb_valid = 0
- arb_data = 8'h00
- arb_first = 0, arb_last = 0
- arb_port = 2'b11
- pkt_abort = 0
- pkt_count = 0
- round-robin pointer reset as in REQ-017
REQ-033 Reset asserted mid-packet discards the packet immediately. The next grant after release follows the reset pointer.

Verification
REQ-034 Port 1 only, header 8'h0D (length 3), arb_ready = 1 -> exactly 5 read_enb_1 pulses; bytes out are header, 3 payload, parity; arb_first on byte 1, arb_last on byte 5; pkt_count = 1.
REQ-035 All three ports valid, each holding one length-1 packet, FIXED_PRIO = 0 -> packets emerge in port order 0, 1, 2; arb_port sequence 0, 1, 2, then 2'b11.
REQ-036 Same stimulus with FIXED_PRIO = 1 and port 0 refilled after each packet -> port 0 granted every time; ports 1 and 2 starve.
REQ-037 arb_ready low for 4 cycles mid-BODY -> no read_enb during the stall; arb_data stable; no bytes lost or duplicated.
REQ-038 vld_out_2 drops after 2 of 5 payload bytes -> reads stop; one pkt_abort pulse; pkt_count unchanged; FSM in IDLE.
REQ-039 Header 8'h00 (length 0) -> 2 reads; header byte then parity byte with arb_last = 1; resetn pulsed low mid-BODY -> all outputs return to reset values asynchronously.
